// File: rtl/scsi_initiator.sv
// scsi_initiator
//   NCR5380-style SCSI initiator with CPU register access and a pseudo-DMA
//   byte engine that runs the REQ/ACK handshake in hardware.
//
// Parameters
//   ACK_HOLD    minimum clocks scsi_ack stays high per DMA byte
//   REQ_SETTLE  clocks scsi_req must be stable (with phase match) before a
//               DMA byte is accepted or delivered
//
// Ports
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   bus_cs, bus_rs, bus_we,     CPU register access (select, index, write/read
//   bus_rd, wdata, rdata          strobes, write data, combinational read data)
//   dack, drq                   pseudo-DMA access strobe / byte-ready request
//   scsi_rst/sel/atn/ack        initiator-driven bus lines
//   scsi_dout                   data to the target
//   scsi_bsy/msg/cd/io/req      target-driven bus lines
//   scsi_din                    data from the target
module scsi_initiator #(
  parameter int ACK_HOLD   = 2,
  parameter int REQ_SETTLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bus_cs,
  input  logic [2:0] bus_rs,
  input  logic       bus_we,
  input  logic       bus_rd,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic       dack,
  output logic       drq,
  output logic       scsi_rst,
  output logic       scsi_sel,
  output logic       scsi_atn,
  output logic       scsi_ack,
  output logic [7:0] scsi_dout,
  input  logic       scsi_bsy,
  input  logic       scsi_msg,
  input  logic       scsi_cd,
  input  logic       scsi_io,
  input  logic       scsi_req,
  input  logic [7:0] scsi_din
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_REQ = 2'd1,
    READY    = 2'd2,
    ACK      = 2'd3
  } dma_state_t;

  localparam int         AW         = $clog2(ACK_HOLD + 1) + 1;
  localparam logic [2:0] SETTLE_MAX = 3'(REQ_SETTLE);

  logic [7:0]     odr;
  logic [7:0]     icr;
  logic [7:0]     mr;
  logic [7:0]     tcr;
  logic [7:0]     dma_data;
  logic [2:0]     settle;
  logic [AW-1:0]  ack_cnt;
  logic           dir;        // 1 = send to target, 0 = receive from target
  dma_state_t     state;

  logic       cpu_wr;
  logic       dma_wr;
  logic       dma_rd;
  logic       phase_match;
  logic       busy_err;
  logic [2:0] settle_inc;
  logic [7:0] reg_val;

  assign cpu_wr      = bus_cs & bus_we;
  // Any dack access that collides with a CPU access is dropped.
  assign dma_wr      = dack & ~bus_cs & bus_we & (state == READY) &  dir;
  assign dma_rd      = dack & ~bus_cs & bus_rd & (state == READY) & ~dir;
  assign phase_match = ({scsi_io, scsi_cd, scsi_msg} == tcr[2:0]);
  assign busy_err    = mr[1] & ~scsi_bsy;
  assign settle_inc  = (settle == SETTLE_MAX) ? SETTLE_MAX : settle + 3'd1;

  assign drq       = (state == READY);
  assign scsi_rst  = icr[7];
  assign scsi_sel  = icr[2];
  assign scsi_atn  = icr[1];
  assign scsi_ack  = icr[4] | (state == ACK);
  assign scsi_dout = (icr[0] | (dir & (state != IDLE))) ? odr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      odr      <= '0;
      icr      <= '0;
      mr       <= '0;
      tcr      <= '0;
      dma_data <= '0;
      settle   <= '0;
      ack_cnt  <= '0;
      dir      <= 1'b0;
      state    <= IDLE;
    end else begin
      if (cpu_wr) begin
        case (bus_rs)
          3'd0:    odr <= wdata;
          3'd1:    icr <= wdata;
          3'd2:    mr  <= wdata;
          3'd3:    tcr <= wdata;
          default: ;
        endcase
      end
      if (dma_wr) odr <= wdata;

      case (state)
        IDLE: ;
        WAIT_REQ: begin
          if (scsi_req && phase_match) begin
            settle <= settle_inc;
            if (settle_inc == SETTLE_MAX) begin
              state <= READY;
              if (!dir) dma_data <= scsi_din;
            end
          end else begin
            settle <= '0;
          end
        end
        READY: begin
          if (dma_wr || dma_rd) begin
            state   <= ACK;
            ack_cnt <= AW'(1);
          end
        end
        ACK: begin
          if (ack_cnt >= AW'(ACK_HOLD) && !scsi_req) begin
            state  <= WAIT_REQ;
            settle <= '0;
          end else if (ack_cnt < AW'(ACK_HOLD)) begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // Start and abort writes are placed last so they override whatever
      // the handshake logic above decided this cycle.
      if (cpu_wr && mr[1] && (bus_rs == 3'd5 || bus_rs == 3'd7)) begin
        state  <= WAIT_REQ;
        dir    <= (bus_rs == 3'd5);
        settle <= '0;
      end
      if (cpu_wr && bus_rs == 3'd2 && !wdata[1]) state <= IDLE;
    end
  end

  always_comb begin
    reg_val = '0;
    case (bus_rs)
      3'd0:    reg_val = scsi_din;
      3'd1:    reg_val = icr;
      3'd2:    reg_val = mr;
      3'd3:    reg_val = tcr;
      3'd4:    reg_val = {scsi_rst, scsi_bsy, scsi_req, scsi_msg,
                          scsi_cd, scsi_io, scsi_sel, 1'b0};
      3'd5:    reg_val = {1'b0, drq, 1'b0, busy_err,
                          phase_match, 1'b0, scsi_atn, scsi_ack};
      3'd6:    reg_val = scsi_din;
      default: reg_val = '0;
    endcase
    rdata = reg_val;
    if (dack && !bus_cs)
      rdata = (state == READY && !dir) ? dma_data : '0;
  end

endmodule

// File: tb/tb_scsi_initiator.sv
// tb_scsi_initiator
//   Directed bench for scsi_initiator: a behavioural target drives the
//   REQ/ACK handshake while the CPU side performs register and pseudo-DMA
//   accesses; expected values are hand-derived constants and target buffers.
module tb_scsi_initiator;

  localparam int ACK_HOLD   = 2;
  localparam int REQ_SETTLE = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bus_cs = 1'b0;
  logic [2:0] bus_rs = '0;
  logic       bus_we = 1'b0;
  logic       bus_rd = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       dack = 1'b0;
  logic       drq;
  logic       scsi_rst, scsi_sel, scsi_atn, scsi_ack;
  logic [7:0] scsi_dout;
  logic       scsi_bsy = 1'b0, scsi_msg = 1'b0, scsi_cd = 1'b0;
  logic       scsi_io = 1'b0, scsi_req = 1'b0;
  logic [7:0] scsi_din = '0;

  scsi_initiator #(.ACK_HOLD(ACK_HOLD), .REQ_SETTLE(REQ_SETTLE)) dut (
    .clk(clk), .reset(reset), .bus_cs(bus_cs), .bus_rs(bus_rs),
    .bus_we(bus_we), .bus_rd(bus_rd), .wdata(wdata), .rdata(rdata),
    .dack(dack), .drq(drq), .scsi_rst(scsi_rst), .scsi_sel(scsi_sel),
    .scsi_atn(scsi_atn), .scsi_ack(scsi_ack), .scsi_dout(scsi_dout),
    .scsi_bsy(scsi_bsy), .scsi_msg(scsi_msg), .scsi_cd(scsi_cd),
    .scsi_io(scsi_io), .scsi_req(scsi_req), .scsi_din(scsi_din)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural target ----------------
  logic [7:0] tgt_tx [0:511];
  logic [7:0] tgt_rx [0:511];
  int         tgt_cnt = 0;
  int         tgt_idx = 0;
  bit         tgt_en = 1'b0;
  int         req_rise = 0;

  initial begin : target
    int w;
    forever begin
      @(posedge clk); #1;
      if (tgt_en && tgt_idx < tgt_cnt) begin
        scsi_din = tgt_tx[tgt_idx];
        scsi_req = 1'b1;
        req_rise = cyc;
        w = 0;
        while (!scsi_ack && w < 300) begin @(posedge clk); #1; w++; end
        if (!scsi_ack) check("tgt_ack_wait", scsi_ack, 1);
        tgt_rx[tgt_idx] = scsi_dout;
        scsi_req = 1'b0;
        w = 0;
        while (scsi_ack && w < 300) begin @(posedge clk); #1; w++; end
        if (scsi_ack) check("tgt_ack_release", scsi_ack, 0);
        tgt_idx++;
      end
    end
  end

  // drq must not rise sooner than REQ_SETTLE clocks after req went high.
  bit chk_settle = 1'b0;
  bit chk_ack = 1'b0;
  logic drq_q = 1'b0;
  int ack_run = 0;
  initial begin : monitors
    forever begin
      @(negedge clk);
      if (chk_settle && drq && !drq_q)
        check("drq_settle", (cyc - req_rise) >= REQ_SETTLE, 1);
      drq_q = drq;
      if (chk_ack) begin
        if (scsi_ack) ack_run++;
        else if (ack_run != 0) begin
          check("ack_hold", ack_run >= ACK_HOLD, 1);
          ack_run = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- CPU-side tasks ----------------
  task automatic cpu_write(input logic [2:0] rs, input logic [7:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b1; bus_rs = rs; wdata = d;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_we = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] rs, output logic [7:0] d);
    @(negedge clk);
    bus_cs = 1'b1; bus_rd = 1'b1; bus_rs = rs;
    #1 d = rdata;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic wait_drq();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (drq) break;
    end
    if (!drq) check("drq_wait", drq, 1);
  endtask

  task automatic dma_read(output logic [7:0] d);
    wait_drq();
    dack = 1'b1; bus_rd = 1'b1;
    #1 d = rdata;
    @(posedge clk); #1;
    dack = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic dma_write(input logic [7:0] d);
    wait_drq();
    dack = 1'b1; bus_we = 1'b1; wdata = d;
    @(posedge clk); #1;
    dack = 1'b0; bus_we = 1'b0;
  endtask

  // dack read with no wait on drq, for accesses outside READY
  task automatic dma_peek(output logic [7:0] d);
    @(negedge clk);
    dack = 1'b1; bus_rd = 1'b1;
    #1 d = rdata;
    @(posedge clk); #1;
    dack = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic wait_req(input logic val);
    logic [7:0] d;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      cpu_read(3'd4, d);
      if (d[5] == val) break;
    end
    if (d[5] != val) check("req_poll", d[5], val);
  endtask

  task automatic wait_target_done();
    for (int i = 0; i < 300; i++) begin
      if (tgt_idx >= tgt_cnt) break;
      @(posedge clk);
    end
    if (tgt_idx < tgt_cnt) check("tgt_done", tgt_idx, tgt_cnt);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    logic [7:0] d;
    logic [7:0] cmd [6];
    cmd = '{8'h12, 8'h00, 8'h00, 8'h00, 8'h24, 8'h00};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_drq", drq, 0);
    check("rst_lines", {scsi_rst, scsi_sel, scsi_atn, scsi_ack}, 4'b0000);
    check("rst_dout", scsi_dout, 8'h00);
    @(negedge clk); reset = 1'b0;
    cpu_read(3'd1, d); check("rst_icr", d, 8'h00);
    cpu_read(3'd2, d); check("rst_mr", d, 8'h00);
    cpu_read(3'd3, d); check("rst_tcr", d, 8'h00);
    // phase 000 equals TCR 000, so only the phase-match bit is set
    cpu_read(3'd5, d); check("rst_reg5", d, 8'h08);

    // Line drive from ICR
    cpu_write(3'd1, 8'h82);
    check("icr_rst_atn", {scsi_rst, scsi_sel, scsi_atn, scsi_ack}, 4'b1010);
    check("icr_nodata", scsi_dout, 8'h00);

    // Selection of target 0
    cpu_write(3'd0, 8'h01);
    cpu_write(3'd1, 8'h05);
    check("sel_line", scsi_sel, 1);
    check("sel_dout", scsi_dout, 8'h01);
    scsi_bsy = 1'b1;
    cpu_read(3'd4, d); check("sel_reg4", d, 8'h42);
    cpu_write(3'd1, 8'h01);

    // Manual handshake in command phase
    scsi_cd = 1'b1;
    cpu_read(3'd5, d); check("cmd_nomatch", d[3], 0);
    tgt_idx = 0; tgt_cnt = 6; tgt_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_req(1'b1);
      cpu_write(3'd0, cmd[i]);
      cpu_write(3'd1, 8'h11);
      wait_req(1'b0);
      cpu_write(3'd1, 8'h01);
    end
    wait_target_done();
    tgt_en = 1'b0;
    for (int i = 0; i < 6; i++) check("cmd_byte", tgt_rx[i], cmd[i]);
    scsi_cd = 1'b0;   // data-out phase
    cpu_read(3'd5, d); check("dout_match", d[3], 1);
    cpu_write(3'd1, 8'h00);

    // DMA receive of 512 bytes in data-in phase
    scsi_io = 1'b1;
    cpu_write(3'd2, 8'h02);
    cpu_write(3'd3, 8'h04);
    cpu_read(3'd5, d); check("din_reg5", d, 8'h08);
    for (int i = 0; i < 512; i++) tgt_tx[i] = 8'((i * 7 + 3) ^ (i >> 8));
    tgt_idx = 0; tgt_cnt = 512;
    chk_settle = 1'b1;
    cpu_write(3'd7, 8'h00);
    tgt_en = 1'b1;
    for (int i = 0; i < 512; i++) begin
      dma_read(d);
      check("rx_byte", d, tgt_tx[i]);
    end
    wait_target_done();
    tgt_en = 1'b0;
    chk_settle = 1'b0;

    // DMA send of 8 bytes in data-out phase
    scsi_io = 1'b0;
    cpu_write(3'd3, 8'h00);
    tgt_idx = 0; tgt_cnt = 8;
    chk_ack = 1'b1; ack_run = 0;
    cpu_write(3'd5, 8'h00);
    tgt_en = 1'b1;
    for (int i = 0; i < 8; i++) dma_write(8'hA0 + 8'(i));
    wait_target_done();
    repeat (4) @(posedge clk);
    tgt_en = 1'b0;
    chk_ack = 1'b0;
    for (int i = 0; i < 8; i++) check("tx_byte", tgt_rx[i], 8'hA0 + 8'(i));

    // Phase mismatch hold, CPU/dack collision, ACK stretch, abort
    cpu_write(3'd0, 8'h5A);
    scsi_io = 1'b1;
    cpu_write(3'd5, 8'h00);
    #1 scsi_req = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("mismatch_hold", drq, 0);
    scsi_io = 1'b0;
    wait_drq();
    @(negedge clk);
    bus_cs = 1'b1; bus_we = 1'b1; bus_rs = 3'd3; wdata = 8'h00; dack = 1'b1;
    @(posedge clk); #1;
    bus_cs = 1'b0; bus_we = 1'b0; dack = 1'b0;
    check("collide_drq", drq, 1);
    check("collide_odr", scsi_dout, 8'h5A);
    dma_write(8'h77);
    repeat (5) @(posedge clk);
    #1;
    check("ack_stretch", scsi_ack, 1);
    check("ack_dout", scsi_dout, 8'h77);
    cpu_write(3'd2, 8'h00);
    check("abort_ack", scsi_ack, 0);
    check("abort_drq", drq, 0);
    dma_peek(d); check("idle_dack", d, 8'h00);
    scsi_req = 1'b0;

    // Reset asserted while READY in receive mode
    cpu_write(3'd2, 8'h02);
    cpu_write(3'd3, 8'h04);
    scsi_io = 1'b1;
    scsi_din = 8'hC3;
    cpu_write(3'd7, 8'h00);
    scsi_req = 1'b1;
    wait_drq();
    check("pre_rst_drq", drq, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_drq", drq, 0);
    check("midrst_dout", scsi_dout, 8'h00);
    @(negedge clk); reset = 1'b0;
    cpu_read(3'd1, d); check("midrst_icr", d, 8'h00);
    cpu_read(3'd2, d); check("midrst_mr", d, 8'h00);
    cpu_read(3'd3, d); check("midrst_tcr", d, 8'h00);
    dma_peek(d); check("midrst_dack", d, 8'h00);
    repeat (10) @(posedge clk);
    #1 check("midrst_stay_idle", drq, 0);
    scsi_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
